// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core: FSM state encodings, parity modes,
// oversampling ratio and the data-mask / parity functions used by TX and RX.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    // bits encodes 5..8 data bits as 0..3
    function automatic logic [7:0] data_mask(input logic [1:0] bits);
        return 8'hFF >> (2'd3 - bits);
    endfunction

    function automatic logic parity_en(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] bits,
                                        input parity_e mode);
        return (^(data & data_mask(bits))) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clk tick16 every baud_div+1 clocks.
// The divisor is only sampled on reload, so changes land cleanly at a period boundary.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] i_baud_div,
    output logic             o_tick16
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (r_cnt == '0)
            r_cnt <= i_baud_div;
        else
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_tick16 = (r_cnt == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: 16x oversampled TX and RX sharing one baud tick, runtime
// configurable 5..8 data bits, none/even/odd parity and 1/2 TX stop bits.
module uart_core
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    output logic             tx_busy,
    input  logic             rxd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_frame_err,
    output logic             rx_parity_err,
    output logic             rx_break,
    output logic             rx_overrun
);

    logic w_tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .i_baud_div (baud_div),
        .o_tick16   (w_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_e   r_tx_state, w_tx_nxt;
    logic [4:0]  r_tx_tick;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx_par;
    logic [1:0]  r_tx_bits;
    parity_e     r_tx_pmode;
    logic        r_tx_stop2;
    logic [4:0]  w_tx_last;
    logic        w_tx_bit_end;
    logic        w_tx_accept;

    assign w_tx_last    = (r_tx_state == TX_STOP && r_tx_stop2) ? 5'd31 : 5'd15;
    assign w_tx_bit_end = w_tick && (r_tx_tick == w_tx_last);
    assign w_tx_accept  = tx_valid && (r_tx_state == TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_nxt;
    end

    always_comb begin
        w_tx_nxt = r_tx_state;
        txd      = 1'b1;
        tx_ready = 1'b0;
        tx_busy  = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
                if (tx_valid) w_tx_nxt = TX_START;
            end
            TX_START: begin
                txd = 1'b0;
                if (w_tx_bit_end) w_tx_nxt = TX_DATA;
            end
            TX_DATA: begin
                txd = r_tx_shift[0];
                if (w_tx_bit_end && r_tx_bit == {1'b0, r_tx_bits} + 3'd4)
                    w_tx_nxt = parity_en(r_tx_pmode) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                txd = r_tx_par;
                if (w_tx_bit_end) w_tx_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (w_tx_bit_end) w_tx_nxt = TX_IDLE;
            end
            default: w_tx_nxt = TX_IDLE;
        endcase
    end

    // Frame config is latched at acceptance so cfg_* may change mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_bits  <= '0;
            r_tx_pmode <= PAR_NONE;
            r_tx_stop2 <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= tx_data;
            r_tx_bits  <= cfg_data_bits;
            r_tx_pmode <= parity_e'(cfg_parity);
            r_tx_stop2 <= cfg_stop2;
            r_tx_par   <= parity_bit(tx_data, cfg_data_bits, parity_e'(cfg_parity));
        end else if (w_tick && r_tx_state != TX_IDLE) begin
            r_tx_tick <= w_tx_bit_end ? 5'd0 : r_tx_tick + 1'b1;
            if (w_tx_bit_end && r_tx_state == TX_DATA) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bit   <= r_tx_bit + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
    end
    assign w_rxd = r_sync[SYNC_STAGES-1];

    rx_state_e   r_rx_state, w_rx_nxt;
    logic [3:0]  r_rx_tick;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_parbit;
    logic [1:0]  r_rx_bits;
    parity_e     r_rx_pmode;
    logic        w_rx_mid;
    logic        w_rx_start;
    logic        w_stop_smp;
    logic [7:0]  w_rx_data;
    logic        w_fe, w_pe, w_brk;
    logic        w_rx_hs;

    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_rx_fe, r_rx_pe, r_rx_brk, r_rx_ovr;

    // Start is confirmed half a bit in; every later sample is a full bit after.
    assign w_rx_mid   = w_tick && (r_rx_tick == ((r_rx_state == RX_START) ? 4'd7 : 4'd15));
    assign w_rx_start = (r_rx_state == RX_IDLE) && w_tick && !w_rxd;
    assign w_stop_smp = (r_rx_state == RX_STOP) && w_rx_mid;

    // Bits shift in from the MSB end; realign short words to bit 0.
    assign w_rx_data = r_rx_shift >> (2'd3 - r_rx_bits);
    assign w_fe      = !w_rxd;
    assign w_pe      = parity_en(r_rx_pmode) &&
                       (r_rx_parbit != parity_bit(w_rx_data, r_rx_bits, r_rx_pmode));
    assign w_brk     = w_fe && (w_rx_data == 8'd0) && !(parity_en(r_rx_pmode) && r_rx_parbit);
    assign w_rx_hs   = r_rx_valid && rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_nxt;
    end

    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:      if (w_tick && !w_rxd) w_rx_nxt = RX_START;
            RX_START:     if (w_rx_mid) w_rx_nxt = w_rxd ? RX_IDLE : RX_DATA;
            RX_DATA:      if (w_rx_mid && r_rx_bit == {1'b0, r_rx_bits} + 3'd4)
                              w_rx_nxt = parity_en(r_rx_pmode) ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (w_rx_mid) w_rx_nxt = RX_STOP;
            RX_STOP:      if (w_rx_mid) w_rx_nxt = w_rxd ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (w_tick && w_rxd) w_rx_nxt = RX_IDLE;
            default:      w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_tick   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_parbit <= 1'b0;
            r_rx_bits   <= '0;
            r_rx_pmode  <= PAR_NONE;
        end else if (w_rx_start) begin
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_bits  <= cfg_data_bits;
            r_rx_pmode <= parity_e'(cfg_parity);
        end else if (w_tick && r_rx_state != RX_IDLE && r_rx_state != RX_WAIT_HIGH) begin
            r_rx_tick <= w_rx_mid ? 4'd0 : r_rx_tick + 1'b1;
            if (w_rx_mid && r_rx_state == RX_DATA) begin
                r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
            if (w_rx_mid && r_rx_state == RX_PARITY)
                r_rx_parbit <= w_rxd;
        end
    end

    // A completed frame is delivered unless the previous byte is still unclaimed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_fe    <= 1'b0;
            r_rx_pe    <= 1'b0;
            r_rx_brk   <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else if (w_stop_smp && (!r_rx_valid || rx_ready)) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= w_rx_data;
            r_rx_fe    <= w_fe;
            r_rx_pe    <= w_pe;
            r_rx_brk   <= w_brk;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (w_rx_hs) begin
                r_rx_valid <= 1'b0;
                r_rx_ovr   <= 1'b0;
            end
            if (w_stop_smp)
                r_rx_ovr <= 1'b1;
        end
    end

    assign rx_valid      = r_rx_valid;
    assign rx_data       = r_rx_data;
    assign rx_frame_err  = r_rx_fe;
    assign rx_parity_err = r_rx_pe;
    assign rx_break      = r_rx_brk;
    assign rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform, loopback and bit-banged RX
// frames scored against an expected-frame queue, plus error, overrun and reset cases.
module tb_uart_core;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] baud_div;
    logic [1:0]       cfg_data_bits;
    logic [1:0]       cfg_parity;
    logic             cfg_stop2;
    logic [7:0]       tx_data;
    logic             tx_valid, tx_ready, txd, tx_busy;
    logic             rxd, rxd_drv, loop_en;
    logic [7:0]       rx_data;
    logic             rx_valid, rx_ready;
    logic             rx_frame_err, rx_parity_err, rx_break, rx_overrun;

    assign rxd = loop_en ? txd : rxd_drv;
    always #5 clk = ~clk;

    uart_core #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_div      (baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_break      (rx_break),
        .rx_overrun    (rx_overrun)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
        logic       ovr;
    } rx_exp_t;

    rx_exp_t sb_q[$];
    rx_exp_t mon_e;
    int      n_chk  = 0;
    int      n_pass = 0;
    int      n_rx   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic rx_exp_t mk_exp(input logic [7:0] d, input logic fe, input logic pe,
                                       input logic brk, input logic ovr);
        rx_exp_t e;
        e.data = d; e.fe = fe; e.pe = pe; e.brk = brk; e.ovr = ovr;
        return e;
    endfunction

    // Score every delivered byte at the negedge before its handshake edge.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            n_rx++;
            if (sb_q.size() == 0) begin
                check("rx_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
                check("rx_flags", 32'({rx_frame_err, rx_parity_err, rx_break, rx_overrun}),
                      32'({mon_e.fe, mon_e.pe, mon_e.brk, mon_e.ovr}));
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_start(input logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 2000) begin
            clks(1);
            t++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int t = 0;
        while (sb_q.size() != 0 && t < max) begin
            clks(1);
            t++;
        end
        check("rx_drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Bit-bang n bits (LSB first) on rxd at the current baud rate.
    task automatic rx_drive(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd_drv = bits[i];
            clks(16 * (int'(baud_div) + 1));
        end
        rxd_drv = 1'b1;
    endtask

    task automatic loop_frame(input logic [7:0] d, input logic [1:0] bits,
                              input logic [1:0] par, input logic stop2);
        logic [7:0] mask;
        mask          = 8'((9'd1 << (int'(bits) + 5)) - 9'd1);
        cfg_data_bits = bits;
        cfg_parity    = par;
        cfg_stop2     = stop2;
        loop_en       = 1'b1;
        sb_q.push_back(mk_exp(d & mask, 1'b0, 1'b0, 1'b0, 1'b0));
        tx_start(d);
        wait_drain(8000);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits_got;
        logic       edge_a, edge_b;
        int         cyc, rx0;

        rst = 1'b1; baud_div = '0; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0; rx_ready = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(2);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_flags", 32'({rx_frame_err, rx_parity_err, rx_break, rx_overrun}), 32'd0);

        // 8N1 0xA5 at one tick per clk
        tx_start(8'hA5);
        check("tx_start_bit", 32'(txd), 32'd0);
        check("tx_busy", 32'(tx_busy), 32'd1);
        check("tx_ready_busy", 32'(tx_ready), 32'd0);
        bits_got = '0; edge_a = 1'b1; edge_b = 1'b0; cyc = 0;
        while (!tx_ready && cyc < 400) begin
            clks(1);
            cyc++;
            if (cyc % 16 == 8 && cyc / 16 < 10) bits_got[cyc / 16] = txd;
            if (cyc == 15) edge_a = txd;
            if (cyc == 16) edge_b = txd;
        end
        check("tx_bits_A5", 32'(bits_got), 32'({1'b1, 8'hA5, 1'b0}));
        check("tx_start_end", 32'(edge_a), 32'd0);
        check("tx_bit0_begin", 32'(edge_b), 32'd1);
        check("tx_frame_clks", 32'(cyc), 32'd160);

        // loopback: 7O2 through a divided baud tick, then 5E2 with ignored upper bits
        baud_div = 16'd2;
        loop_frame(8'h35, 2'd2, 2'd2, 1'b1);
        loop_frame(8'hFF, 2'd0, 2'd1, 1'b1);
        baud_div = 16'd1;
        for (int i = 0; i < 6; i++)
            loop_frame(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
        loop_en  = 1'b0;
        baud_div = '0;
        clks(40);

        // 8E1 0x0F with parity bit forced wrong (correct even parity is 0)
        cfg_data_bits = 2'd3; cfg_parity = 2'd1; cfg_stop2 = 1'b0;
        sb_q.push_back(mk_exp(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0));
        rx_drive({5'd0, 1'b1, 1'b1, 8'h0F, 1'b0}, 11);
        clks(20);
        wait_drain(200);

        // framing error with non-zero data: no break
        cfg_parity = 2'd0;
        sb_q.push_back(mk_exp(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
        rx_drive({6'd0, 1'b0, 8'h3C, 1'b0}, 10);
        clks(40);
        wait_drain(200);

        // line held low for 20 bit times -> one break frame, then silence
        rx0 = n_rx;
        sb_q.push_back(mk_exp(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        rxd_drv = 1'b0;
        clks(20 * 16);
        check("break_frames", 32'(n_rx - rx0), 32'd1);
        rxd_drv = 1'b1;
        clks(40);
        sb_q.push_back(mk_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
        rx_drive({6'd0, 1'b1, 8'h5A, 1'b0}, 10);
        clks(20);
        wait_drain(200);

        // overrun: second frame dropped while first is unclaimed
        rx_ready = 1'b0;
        sb_q.push_back(mk_exp(8'h11, 1'b0, 1'b0, 1'b0, 1'b1));
        rx_drive({6'd0, 1'b1, 8'h11, 1'b0}, 10);
        rx_drive({6'd0, 1'b1, 8'h22, 1'b0}, 10);
        clks(20);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        check("ovr_data_hold", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        wait_drain(50);
        check("ovr_valid_clr", 32'(rx_valid), 32'd0);
        check("ovr_flag_clr", 32'(rx_overrun), 32'd0);

        // 4-clk glitch must not start a frame
        rx0 = n_rx;
        rxd_drv = 1'b0;
        clks(4);
        rxd_drv = 1'b1;
        clks(300);
        check("glitch_frames", 32'(n_rx - rx0), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);

        // asynchronous reset in the middle of a looped-back frame
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        loop_en = 1'b1;
        rx0 = n_rx;
        tx_start(8'h00);
        clks(50);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_txd", 32'(txd), 32'd1);
        check("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_mid_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        clks(2);
        rst = 1'b0;
        clks(400);
        check("rst_mid_rx_frames", 32'(n_rx - rx0), 32'd0);
        check("rst_mid_rx_valid2", 32'(rx_valid), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of the runtime baud divisor.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning RX input synchroniser depth (>=2).
REQ-003 SHALL have clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have baud_div, input, DIV_W, oversample tick period minus 1 (tick every baud_div+1 clk).
REQ-006 SHALL have cfg_data_bits, input, 2, data length 0..3 = 5..8 bits.
REQ-007 SHALL have cfg_parity, input, 2, 0 none, 1 even, 2 odd, 3 treated as none.
REQ-008 SHALL have cfg_stop2, input, 1, 1 = two TX stop bits.
REQ-009 SHALL have tx_data / tx_valid / tx_ready, input 8 / input 1 / output 1, TX byte handshake.
REQ-010 SHALL have txd, output, 1, serial transmit line; tx_busy, output, 1, frame in progress.
REQ-011 SHALL have rxd, input, 1, asynchronous serial receive line.
REQ-012 SHALL have rx_data / rx_valid / rx_ready, output 8 / output 1 / input 1, RX byte handshake.
REQ-013 SHALL have rx_frame_err, rx_parity_err, rx_break, rx_overrun, outputs, 1 each, status qualified by rx_valid (overrun sticky).

Function
REQ-014 SHALL generate tick16 one clk wide every baud_div+1 clk; baud_div=0 gives tick16 every clk; one bit = 16 ticks.
REQ-015 TX states SHALL be TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP.
REQ-016 tx_ready SHALL be 1 only in TX_IDLE; transfer on tx_valid&&tx_ready captures tx_data and cfg_* for the whole frame.
REQ-017 txd SHALL drive start bit 0 from the clk after acceptance; TX bit-tick counter restarts at acceptance.
REQ-018 TX SHALL send data LSB first, cfg_data_bits+5 bits; unused upper tx_data bits ignored.
REQ-019 Parity bit SHALL be XOR of sent bits (even) or its inverse (odd); TX_PARITY skipped when none.
REQ-020 TX_STOP SHALL hold txd=1 for 16 or 32 ticks (cfg_stop2), then TX_IDLE; tx_busy=1 in all states except TX_IDLE.
REQ-021 RX states SHALL be RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH.
REQ-022 RX_IDLE SHALL enter RX_START on synchronised rxd=0 at a tick16.
REQ-023 RX_START SHALL resample at tick 8; if rxd=1, return to RX_IDLE (glitch, no output).
REQ-024 RX SHALL sample each subsequent bit 16 ticks later (mid-bit); only the first stop bit is checked.
REQ-025 At stop sample: rx_data = received bits zero-extended; rx_frame_err = stop bit 0; rx_parity_err = parity mismatch (0 if none); rx_break = frame_err and all data and parity bits 0.
REQ-026 rx_valid SHALL rise the clk after stop sample and stay until rx_valid&&rx_ready; rx_data/flags stable while rx_valid=1.
REQ-027 Frame completing while rx_valid=1 SHALL be discarded and set rx_overrun; rx_overrun clears on the next handshake.
REQ-028 On frame_err RX SHALL enter RX_WAIT_HIGH and return to RX_IDLE only after sampling rxd=1.
REQ-029 cfg_* changes SHALL affect RX from the next RX_START; baud_div changes take effect at next tick16 counter reload.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 Reset SHALL force txd=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error flags 0, both FSMs idle, synchroniser to 1.
REQ-032 Reset mid-frame SHALL abort both frames immediately with no partial rx_valid.

Structure
REQ-033 uart_pkg SHALL hold tx/rx state enums, parity-mode enum and OVERSAMPLE=16 constant.
REQ-034 Baud tick generation SHALL be one sub-module uart_baud_gen shared by TX and RX.

Verification
REQ-035 baud_div=0, 8N1, send 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1, 16 clk per bit, tx_ready back after 160 clk.
REQ-036 Loopback txd->rxd, 7 bits odd parity, 2 stop, send 0x35 -> rx_data=0x35, rx_valid=1, all errors 0.
REQ-037 Inject wrong parity bit on rxd, even parity, 0x0F -> rx_parity_err=1, rx_data=0x0F.
REQ-038 Hold rxd low 20 bit times -> rx_break=1, rx_frame_err=1, no new frame until rxd high.
REQ-039 rx_ready=0, two frames 0x11 then 0x22 -> rx_data=0x11, rx_overrun=1; handshake clears both.
REQ-040 4-tick rxd low pulse -> no rx_valid; rst asserted mid-TX -> txd=1, tx_ready=1 same cycle.
